exu_bru_pipe: RTL and testbench



---
 rtl/exu_bru_pipe.sv | 198 +++++++++++++++++++
 tb/tb_exu_bru_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_bru_pipe.sv
// ---------------------------------------------------------------------------
// exu_bru_pipe: registered execute-stage branch unit.
//
// Accepts one JAL/JALR/Bxx/FENCE request per cycle over valid/ready, resolves
// it against the front-end prediction and presents the result to commit
// through a single-entry output register. A mispredict (or an interrupt)
// produces a registered one-cycle redirect pulse. Two wrap-around counters
// track resolved requests and mispredicts.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_*                    request handshake and operands
//   flush_i                  drops held result, blocks accept
//   int_assert_i, int_addr_i interrupt redirect (highest priority)
//   res_*                    resolved result to commit (valid/ready)
//   jump_flag_o, jump_addr_o redirect pulse and address
//   br_cnt_o, mispred_cnt_o  statistics counters
// ---------------------------------------------------------------------------
module exu_bru_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned HAS_C = 0,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [3:0]       req_op_i,
   input  logic [XLEN-1:0]  req_op1_i,
   input  logic [XLEN-1:0]  req_op2_i,
   input  logic [XLEN-1:0]  req_jop1_i,
   input  logic [XLEN-1:0]  req_jop2_i,
   input  logic [XLEN-1:0]  req_pc_i,
   input  logic             req_pred_taken_i,
   input  logic [XLEN-1:0]  req_pred_target_i,
   input  logic [TAG_W-1:0] req_tag_i,
   input  logic             flush_i,
   input  logic             int_assert_i,
   input  logic [XLEN-1:0]  int_addr_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic             res_taken_o,
   output logic [XLEN-1:0]  res_target_o,
   output logic             res_mispred_o,
   output logic             res_misalign_o,
   output logic [TAG_W-1:0] res_tag_o,
   output logic             jump_flag_o,
   output logic [XLEN-1:0]  jump_addr_o,
   output logic [CNT_W-1:0] br_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   localparam logic [3:0] OpJal   = 4'd0;
   localparam logic [3:0] OpJalr  = 4'd1;
   localparam logic [3:0] OpBeq   = 4'd2;
   localparam logic [3:0] OpBne   = 4'd3;
   localparam logic [3:0] OpBlt   = 4'd4;
   localparam logic [3:0] OpBge   = 4'd5;
   localparam logic [3:0] OpBltu  = 4'd6;
   localparam logic [3:0] OpBgeu  = 4'd7;
   localparam logic [3:0] OpFence = 4'd8;

   logic             res_valid_q, res_valid_d;
   logic             res_taken_q, res_taken_d;
   logic [XLEN-1:0]  res_target_q, res_target_d;
   logic             res_mispred_q, res_mispred_d;
   logic             res_misalign_q, res_misalign_d;
   logic [TAG_W-1:0] res_tag_q, res_tag_d;
   logic             jump_flag_q, jump_flag_d;
   logic [XLEN-1:0]  jump_addr_q, jump_addr_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   logic            accept;
   logic [XLEN-1:0] sum_raw, sum, fallthrough, target;
   logic            taken, misalign, mispred;
   logic            is_eq, is_lt, is_ltu;

   // Held low during reset so every output reads 0 while rst is high.
   assign req_ready_o = (~res_valid_q | res_ready_i) & ~flush_i & ~int_assert_i & ~rst;
   assign accept      = req_valid_i & req_ready_o;

   // Resolution
   assign sum_raw     = req_jop1_i + req_jop2_i;
   assign sum         = (req_op_i == OpJalr) ? {sum_raw[XLEN-1:1], 1'b0} : sum_raw;
   assign fallthrough = req_pc_i + XLEN'(4);
   assign is_eq       = (req_op1_i == req_op2_i);
   assign is_lt       = ($signed(req_op1_i) < $signed(req_op2_i));
   assign is_ltu      = (req_op1_i < req_op2_i);

   always_comb begin
      taken = 1'b0;
      case (req_op_i)
         OpJal, OpJalr, OpFence: taken = 1'b1;
         OpBeq:                  taken = is_eq;
         OpBne:                  taken = ~is_eq;
         OpBlt:                  taken = is_lt;
         OpBge:                  taken = ~is_lt;
         OpBltu:                 taken = is_ltu;
         OpBgeu:                 taken = ~is_ltu;
         default:                taken = 1'b0;
      endcase
   end

   assign target   = taken ? sum : fallthrough;
   assign misalign = taken & ((HAS_C != 0) ? sum[0] : |sum[1:0]);

   always_comb begin
      if (req_op_i == OpFence) begin
         mispred = 1'b1;
      end else if (misalign) begin
         mispred = 1'b0;
      end else begin
         mispred = (taken != req_pred_taken_i) | (taken & (sum != req_pred_target_i));
      end
   end

   // Next state: interrupt > flush > accept > hand-off
   always_comb begin
      res_valid_d    = res_valid_q;
      res_taken_d    = res_taken_q;
      res_target_d   = res_target_q;
      res_mispred_d  = res_mispred_q;
      res_misalign_d = res_misalign_q;
      res_tag_d      = res_tag_q;
      jump_flag_d    = 1'b0;
      jump_addr_d    = jump_addr_q;
      br_cnt_d       = br_cnt_q;
      mispred_cnt_d  = mispred_cnt_q;

      if (int_assert_i || flush_i) begin
         res_valid_d = 1'b0;
      end else if (accept) begin
         res_valid_d    = 1'b1;
         res_taken_d    = taken;
         res_target_d   = target;
         res_mispred_d  = mispred;
         res_misalign_d = misalign;
         res_tag_d      = req_tag_i;
      end else if (res_ready_i) begin
         res_valid_d = 1'b0;
      end

      if (int_assert_i) begin
         jump_flag_d = 1'b1;
         jump_addr_d = int_addr_i;
      end else if (accept && mispred) begin
         jump_flag_d = 1'b1;
         jump_addr_d = target;
      end

      if (accept) begin
         br_cnt_d = br_cnt_q + CNT_W'(1);
         if (mispred) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid_q    <= 1'b0;
         res_taken_q    <= 1'b0;
         res_target_q   <= '0;
         res_mispred_q  <= 1'b0;
         res_misalign_q <= 1'b0;
         res_tag_q      <= '0;
         jump_flag_q    <= 1'b0;
         jump_addr_q    <= '0;
         br_cnt_q       <= '0;
         mispred_cnt_q  <= '0;
      end else begin
         res_valid_q    <= res_valid_d;
         res_taken_q    <= res_taken_d;
         res_target_q   <= res_target_d;
         res_mispred_q  <= res_mispred_d;
         res_misalign_q <= res_misalign_d;
         res_tag_q      <= res_tag_d;
         jump_flag_q    <= jump_flag_d;
         jump_addr_q    <= jump_addr_d;
         br_cnt_q       <= br_cnt_d;
         mispred_cnt_q  <= mispred_cnt_d;
      end
   end

   assign res_valid_o    = res_valid_q;
   assign res_taken_o    = res_taken_q;
   assign res_target_o   = res_target_q;
   assign res_mispred_o  = res_mispred_q;
   assign res_misalign_o = res_misalign_q;
   assign res_tag_o      = res_tag_q;
   assign jump_flag_o    = jump_flag_q;
   assign jump_addr_o    = jump_addr_q;
   assign br_cnt_o       = br_cnt_q;
   assign mispred_cnt_o  = mispred_cnt_q;

endmodule

// File: tb/tb_exu_bru_pipe.sv
// ---------------------------------------------------------------------------
// tb_exu_bru_pipe: directed bench for exu_bru_pipe.
// dut  : HAS_C=0, CNT_W=32 (main checks)
// dut2 : HAS_C=1, CNT_W=4, same inputs (compressed alignment, counter wrap)
// ---------------------------------------------------------------------------
module tb_exu_bru_pipe;

   localparam logic [3:0] OpJal   = 4'd0;
   localparam logic [3:0] OpJalr  = 4'd1;
   localparam logic [3:0] OpBeq   = 4'd2;
   localparam logic [3:0] OpBne   = 4'd3;
   localparam logic [3:0] OpBlt   = 4'd4;
   localparam logic [3:0] OpBge   = 4'd5;
   localparam logic [3:0] OpBltu  = 4'd6;
   localparam logic [3:0] OpFence = 4'd8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic [3:0]  req_op_i;
   logic [31:0] req_op1_i, req_op2_i, req_jop1_i, req_jop2_i, req_pc_i;
   logic        req_pred_taken_i;
   logic [31:0] req_pred_target_i;
   logic [3:0]  req_tag_i;
   logic        flush_i, int_assert_i, res_ready_i;
   logic [31:0] int_addr_i;

   logic        req_ready_o, res_valid_o, res_taken_o, res_mispred_o, res_misalign_o;
   logic [31:0] res_target_o, jump_addr_o, br_cnt_o, mispred_cnt_o;
   logic [3:0]  res_tag_o;
   logic        jump_flag_o;

   logic        req_ready2, res_valid2, res_taken2, res_mispred2, res_misalign2, jump_flag2;
   logic [31:0] res_target2, jump_addr2;
   logic [3:0]  res_tag2, br_cnt2, mispred_cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   exu_bru_pipe #(.XLEN(32), .HAS_C(0), .TAG_W(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_jop1_i(req_jop1_i),
      .req_jop2_i(req_jop2_i), .req_pc_i(req_pc_i), .req_pred_taken_i(req_pred_taken_i),
      .req_pred_target_i(req_pred_target_i), .req_tag_i(req_tag_i), .flush_i(flush_i),
      .int_assert_i(int_assert_i), .int_addr_i(int_addr_i), .res_valid_o(res_valid_o),
      .res_ready_i(res_ready_i), .res_taken_o(res_taken_o), .res_target_o(res_target_o),
      .res_mispred_o(res_mispred_o), .res_misalign_o(res_misalign_o), .res_tag_o(res_tag_o),
      .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .br_cnt_o(br_cnt_o),
      .mispred_cnt_o(mispred_cnt_o)
   );

   exu_bru_pipe #(.XLEN(32), .HAS_C(1), .TAG_W(4), .CNT_W(4)) dut2 (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready2), .req_op_i(req_op_i),
      .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_jop1_i(req_jop1_i),
      .req_jop2_i(req_jop2_i), .req_pc_i(req_pc_i), .req_pred_taken_i(req_pred_taken_i),
      .req_pred_target_i(req_pred_target_i), .req_tag_i(req_tag_i), .flush_i(flush_i),
      .int_assert_i(int_assert_i), .int_addr_i(int_addr_i), .res_valid_o(res_valid2),
      .res_ready_i(res_ready_i), .res_taken_o(res_taken2), .res_target_o(res_target2),
      .res_mispred_o(res_mispred2), .res_misalign_o(res_misalign2), .res_tag_o(res_tag2),
      .jump_flag_o(jump_flag2), .jump_addr_o(jump_addr2), .br_cnt_o(br_cnt2),
      .mispred_cnt_o(mispred_cnt2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [3:0] op, input logic [31:0] op1, input logic [31:0] op2,
                          input logic [31:0] j1, input logic [31:0] j2, input logic [31:0] pc,
                          input logic pt, input logic [31:0] ptgt, input logic [3:0] tag);
      req_valid_i       = 1'b1;
      req_op_i          = op;
      req_op1_i         = op1;
      req_op2_i         = op2;
      req_jop1_i        = j1;
      req_jop2_i        = j2;
      req_pc_i          = pc;
      req_pred_taken_i  = pt;
      req_pred_target_i = ptgt;
      req_tag_i         = tag;
   endtask

   initial begin
      rst = 1'b1;
      req_valid_i = 1'b0; req_op_i = '0; req_op1_i = '0; req_op2_i = '0;
      req_jop1_i = '0; req_jop2_i = '0; req_pc_i = '0; req_pred_taken_i = 1'b0;
      req_pred_target_i = '0; req_tag_i = '0; flush_i = 1'b0; int_assert_i = 1'b0;
      int_addr_i = '0; res_ready_i = 1'b1;
      step();
      step();

      // Reset state
      check("rst_res_valid", res_valid_o, 0);
      check("rst_jump_flag", jump_flag_o, 0);
      check("rst_jump_addr", jump_addr_o, 0);
      check("rst_br_cnt", br_cnt_o, 0);
      check("rst_mispred_cnt", mispred_cnt_o, 0);
      check("rst_req_ready", req_ready_o, 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", req_ready_o, 1);

      // BEQ taken, predicted not taken -> redirect
      set_req(OpBeq, 32'd5, 32'd5, 32'h100, 32'h20, 32'h100, 1'b0, 32'h0, 4'd3);
      step();
      req_valid_i = 1'b0;
      check("beq_valid", res_valid_o, 1);
      check("beq_taken", res_taken_o, 1);
      check("beq_target", res_target_o, 32'h120);
      check("beq_mispred", res_mispred_o, 1);
      check("beq_tag", res_tag_o, 3);
      check("beq_jflag", jump_flag_o, 1);
      check("beq_jaddr", jump_addr_o, 32'h120);
      check("beq_mcnt", mispred_cnt_o, 1);
      check("beq_bcnt", br_cnt_o, 1);
      step();
      check("beq_jflag_pulse", jump_flag_o, 0);
      check("beq_jaddr_hold", jump_addr_o, 32'h120);
      check("beq_handoff", res_valid_o, 0);

      // BLT signed taken, then BLTU unsigned not taken, back to back
      set_req(OpBlt, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 32'h200, 1'b1, 32'h240, 4'd1);
      step();
      check("blt_taken", res_taken_o, 1);
      check("blt_target", res_target_o, 32'h240);
      check("blt_jflag", jump_flag_o, 0);
      set_req(OpBltu, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 32'h200, 1'b0, 32'h0, 4'd2);
      step();
      req_valid_i = 1'b0;
      check("bltu_valid", res_valid_o, 1);
      check("bltu_taken", res_taken_o, 0);
      check("bltu_target", res_target_o, 32'h204);
      check("bltu_tag", res_tag_o, 2);
      check("bltu_jflag", jump_flag_o, 0);
      check("bltu_bcnt", br_cnt_o, 3);

      // JALR misaligned under 4-byte alignment, legal with compressed
      set_req(OpJalr, 32'h0, 32'h0, 32'h2001, 32'h2, 32'h300, 1'b1, 32'h2002, 4'd4);
      step();
      req_valid_i = 1'b0;
      check("jalr_target", res_target_o, 32'h2002);
      check("jalr_misalign", res_misalign_o, 1);
      check("jalr_mispred", res_mispred_o, 0);
      check("jalr_jflag", jump_flag_o, 0);
      check("jalr_c_misalign", res_misalign2, 0);
      check("jalr_c_target", res_target2, 32'h2002);
      step();

      // Back-pressure: hold result for three cycles
      res_ready_i = 1'b0;
      set_req(OpBge, 32'd3, 32'd3, 32'h400, 32'h8, 32'h400, 1'b1, 32'h408, 4'd5);
      step();
      set_req(OpBne, 32'd1, 32'd2, 32'h500, 32'h10, 32'h500, 1'b1, 32'h510, 4'd6);
      for (int i = 0; i < 3; i++) begin
         check("bp_ready_low", req_ready_o, 0);
         check("bp_tag_stable", res_tag_o, 5);
         check("bp_target_stable", res_target_o, 32'h408);
         step();
      end
      res_ready_i = 1'b1;
      #1;
      check("bp_release_ready", req_ready_o, 1);
      step();
      req_valid_i = 1'b0;
      check("bp_next_valid", res_valid_o, 1);
      check("bp_next_tag", res_tag_o, 6);
      check("bp_next_target", res_target_o, 32'h510);
      check("bp_bcnt", br_cnt_o, 6);
      step();

      // Interrupt wins over a valid request
      set_req(OpBeq, 32'd1, 32'd1, 32'h900, 32'h4, 32'h900, 1'b0, 32'h0, 4'd8);
      int_assert_i = 1'b1;
      int_addr_i   = 32'h80;
      #1;
      check("int_ready_low", req_ready_o, 0);
      step();
      int_assert_i = 1'b0;
      req_valid_i  = 1'b0;
      check("int_jflag", jump_flag_o, 1);
      check("int_jaddr", jump_addr_o, 32'h80);
      check("int_res_valid", res_valid_o, 0);
      check("int_bcnt", br_cnt_o, 6);
      check("int_mcnt", mispred_cnt_o, 1);
      step();
      check("int_jflag_pulse", jump_flag_o, 0);
      check("int_jaddr_hold", jump_addr_o, 32'h80);

      // FENCE always redirects; then a flush drops it and blocks a request
      res_ready_i = 1'b0;
      set_req(OpFence, 32'h0, 32'h0, 32'h600, 32'h4, 32'h600, 1'b0, 32'h0, 4'd7);
      step();
      check("fence_mispred", res_mispred_o, 1);
      check("fence_jflag", jump_flag_o, 1);
      check("fence_jaddr", jump_addr_o, 32'h604);
      check("fence_mcnt", mispred_cnt_o, 2);
      flush_i = 1'b1;
      set_req(OpBeq, 32'd1, 32'd1, 32'hA00, 32'h4, 32'hA00, 1'b0, 32'h0, 4'd9);
      #1;
      check("flush_ready_low", req_ready_o, 0);
      step();
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      res_ready_i = 1'b1;
      check("flush_res_valid", res_valid_o, 0);
      check("flush_jflag", jump_flag_o, 0);
      check("flush_bcnt", br_cnt_o, 7);

      // Illegal opcode resolves not-taken
      set_req(4'd12, 32'h0, 32'h0, 32'h0, 32'h0, 32'h700, 1'b0, 32'h0, 4'd10);
      step();
      req_valid_i = 1'b0;
      check("ill_taken", res_taken_o, 0);
      check("ill_target", res_target_o, 32'h704);
      check("ill_jflag", jump_flag_o, 0);
      check("ill_bcnt", br_cnt_o, 8);

      // Eight more correctly predicted JALs: 4-bit counter wraps 15 -> 0
      set_req(OpJal, 32'h0, 32'h0, 32'h800, 32'h0, 32'h7F0, 1'b1, 32'h800, 4'd11);
      for (int i = 0; i < 7; i++) step();
      check("wrap_c_bcnt_15", br_cnt2, 4'hF);
      step();
      req_valid_i = 1'b0;
      check("wrap_bcnt", br_cnt_o, 16);
      check("wrap_c_bcnt", br_cnt2, 4'h0);
      check("wrap_mcnt", mispred_cnt_o, 2);
      check("wrap_c_mcnt", mispred_cnt2, 4'h2);

      // Asynchronous reset mid-operation
      set_req(OpBeq, 32'd1, 32'd1, 32'hB00, 32'h4, 32'hB00, 1'b0, 32'h0, 4'd12);
      step();
      check("pre_rst_jflag", jump_flag_o, 1);
      rst = 1'b1;
      #1;
      check("arst_res_valid", res_valid_o, 0);
      check("arst_jflag", jump_flag_o, 0);
      check("arst_jaddr", jump_addr_o, 0);
      check("arst_target", res_target_o, 0);
      check("arst_bcnt", br_cnt_o, 0);
      check("arst_mcnt", mispred_cnt_o, 0);
      check("arst_ready", req_ready_o, 0);
      req_valid_i = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
